// File: rtl/sdu_host_agent.sv
// Host-terminal stand-in for the debug command processor: sends one buffered command line,
// then collects the reply until PROMPT. Optional reply inactivity timeout: SDU_HOST_TIMEOUT_EN.
module sdu_host_agent #(
    parameter int          CMD_DEPTH   = 32,
    parameter int          RSP_DEPTH   = 64,
    parameter logic [7:0]  PROMPT      = 8'h3E,
    parameter int          TIMEOUT_CYC = 1000000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_we,
    input  logic [7:0]                     cmd_wd,
    output logic                           cmd_full,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic [7:0]                     out_d,
    output logic                           out_vld,
    input  logic                           out_rdy,
    input  logic [7:0]                     in_d,
    input  logic                           in_vld,
    output logic                           in_rdy,
    input  logic                           rsp_rd,
    output logic [7:0]                     rsp_rdata,
    output logic [$clog2(RSP_DEPTH):0]     rsp_cnt,
    output logic [7:0]                     rsp_sum,
    output logic                           ovf,
    output logic                           timeout
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [7:0]     cmd_mem [CMD_DEPTH];
    logic [7:0]     rsp_mem [RSP_DEPTH];
    logic [CAW-1:0] cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
    logic [CAW:0]   cmd_cnt_q, cmd_cnt_d;
    logic [RAW-1:0] rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
    logic [RAW:0]   rsp_cnt_q, rsp_cnt_d;
    logic [7:0]     rsp_sum_q, rsp_sum_d;
    logic           ovf_q, ovf_d;
    logic           edone_q, edone_d;
    logic           cmd_wen, rsp_wen, in_fire, out_fire;

`ifdef SDU_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic           timeout_q, timeout_d;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign cmd_full  = (cmd_cnt_q == (CAW+1)'(CMD_DEPTH));
    assign out_vld   = (state_q == S_SEND);
    assign out_d     = out_vld ? cmd_mem[cmd_rp_q] : 8'h00;
    assign busy      = (state_q == S_SEND) || (state_q == S_WAIT);
    assign in_rdy    = busy;
    assign done      = (state_q == S_DONE) || edone_q;
    assign rsp_rdata = rsp_mem[rsp_rp_q];
    assign rsp_cnt   = rsp_cnt_q;
    assign rsp_sum   = rsp_sum_q;
    assign ovf       = ovf_q;
    assign in_fire   = in_vld && in_rdy;
    assign out_fire  = out_vld && out_rdy;

    always_comb begin
        state_d   = state_q;
        cmd_wp_d  = cmd_wp_q;
        cmd_rp_d  = cmd_rp_q;
        cmd_cnt_d = cmd_cnt_q;
        rsp_wp_d  = rsp_wp_q;
        rsp_rp_d  = rsp_rp_q;
        rsp_cnt_d = rsp_cnt_q;
        rsp_sum_d = rsp_sum_q;
        ovf_d     = ovf_q;
        edone_d   = 1'b0;
        cmd_wen   = 1'b0;
        rsp_wen   = 1'b0;
`ifdef SDU_HOST_TIMEOUT_EN
        to_cnt_d  = '0;
        timeout_d = timeout_q;
`endif

        // Echo and reply bytes are captured in both SEND and WAIT; the sum never drops one.
        if (in_fire) begin
            rsp_sum_d = rsp_sum_q + in_d;
            if (rsp_cnt_q < (RAW+1)'(RSP_DEPTH)) begin
                rsp_wen   = 1'b1;
                rsp_wp_d  = rsp_wp_q + 1'b1;
                rsp_cnt_d = rsp_cnt_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) state_d = S_IDLE;
                if (state_q == S_IDLE && cmd_we && !cmd_full) begin
                    cmd_wen   = 1'b1;
                    cmd_wp_d  = cmd_wp_q + 1'b1;
                    cmd_cnt_d = cmd_cnt_q + 1'b1;
                end
                if (state_q == S_IDLE && start) begin
                    if (cmd_cnt_d != '0) begin
                        rsp_wp_d  = '0;
                        rsp_rp_d  = '0;
                        rsp_cnt_d = '0;
                        rsp_sum_d = '0;
                        ovf_d     = 1'b0;
`ifdef SDU_HOST_TIMEOUT_EN
                        timeout_d = 1'b0;
`endif
                        state_d   = S_SEND;
                    end else begin
                        edone_d = 1'b1;
                    end
                end else if (rsp_rd && rsp_cnt_q != '0) begin
                    rsp_rp_d  = rsp_rp_q + 1'b1;
                    rsp_cnt_d = rsp_cnt_q - 1'b1;
                end
            end
            S_SEND: begin
                if (out_fire) begin
                    cmd_rp_d  = cmd_rp_q + 1'b1;
                    cmd_cnt_d = cmd_cnt_q - 1'b1;
                    if (cmd_cnt_q == (CAW+1)'(1)) begin
                        cmd_wp_d  = '0;
                        cmd_rp_d  = '0;
                        cmd_cnt_d = '0;
                        state_d   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (in_fire && in_d == PROMPT) begin
                    state_d = S_DONE;
                end
`ifdef SDU_HOST_TIMEOUT_EN
                else if (!in_fire) begin
                    if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cmd_wp_q  <= '0;
            cmd_rp_q  <= '0;
            cmd_cnt_q <= '0;
            rsp_wp_q  <= '0;
            rsp_rp_q  <= '0;
            rsp_cnt_q <= '0;
            rsp_sum_q <= '0;
            ovf_q     <= 1'b0;
            edone_q   <= 1'b0;
`ifdef SDU_HOST_TIMEOUT_EN
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_wp_q  <= cmd_wp_d;
            cmd_rp_q  <= cmd_rp_d;
            cmd_cnt_q <= cmd_cnt_d;
            rsp_wp_q  <= rsp_wp_d;
            rsp_rp_q  <= rsp_rp_d;
            rsp_cnt_q <= rsp_cnt_d;
            rsp_sum_q <= rsp_sum_d;
            ovf_q     <= ovf_d;
            edone_q   <= edone_d;
`ifdef SDU_HOST_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Buffer storage carries no reset; pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (cmd_wen) cmd_mem[cmd_wp_q] <= cmd_wd;
        if (rsp_wen) rsp_mem[rsp_wp_q] <= in_d;
    end

endmodule

// File: tb/tb_sdu_host_agent.sv
// Directed bench for sdu_host_agent: send path, stalls, buffer limits, reply overflow, reset abort.
module tb_sdu_host_agent;
    logic       clk = 1'b0;
    logic       rst, cmd_we, start, out_rdy, in_vld, rsp_rd;
    logic [7:0] cmd_wd, in_d;
    logic       cmd_full, busy, done, out_vld, in_rdy, ovf, timeout;
    logic [7:0] out_d, rsp_rdata, rsp_sum;
    logic [6:0] rsp_cnt;
    int tests = 0;
    int fails = 0;

    sdu_host_agent #(.CMD_DEPTH(32), .RSP_DEPTH(64), .PROMPT(8'h3E), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst(rst), .cmd_we(cmd_we), .cmd_wd(cmd_wd), .cmd_full(cmd_full),
        .start(start), .busy(busy), .done(done), .out_d(out_d), .out_vld(out_vld),
        .out_rdy(out_rdy), .in_d(in_d), .in_vld(in_vld), .in_rdy(in_rdy), .rsp_rd(rsp_rd),
        .rsp_rdata(rsp_rdata), .rsp_cnt(rsp_cnt), .rsp_sum(rsp_sum), .ovf(ovf), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        cmd_we = 1'b1; cmd_wd = b;
        tick();
        cmd_we = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b);
        in_vld = 1'b1; in_d = b;
        tick();
        in_vld = 1'b0;
    endtask

    initial begin
        logic [7:0] exp2 [2];
        int hs, n;
        exp2[0] = 8'h50; exp2[1] = 8'h0D;
        rst = 1'b1; cmd_we = 0; cmd_wd = 0; start = 0; out_rdy = 1; in_vld = 0; in_d = 0; rsp_rd = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        chk("rst_out_vld", out_vld, 0); chk("rst_out_d", out_d, 0);
        chk("rst_in_rdy", in_rdy, 0);   chk("rst_cmd_full", cmd_full, 0);
        chk("rst_rsp_cnt", rsp_cnt, 0); chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_ovf", ovf, 0);         chk("rst_timeout", timeout, 0);

        // Basic transaction
        wr(8'h50); wr(8'h0D);
        start = 1; tick(); start = 0;
        chk("t1_vld0", out_vld, 1); chk("t1_d0", out_d, 8'h50); chk("t1_busy", busy, 1);
        tick();
        chk("t1_vld1", out_vld, 1); chk("t1_d1", out_d, 8'h0D);
        tick();
        chk("t1_wait_vld", out_vld, 0); chk("t1_wait_busy", busy, 1); chk("t1_wait_rdy", in_rdy, 1);
        rx(8'h41);
        chk("t1_no_done", done, 0);
        rx(8'h3E);
        chk("t1_done", done, 1); chk("t1_done_rdy", in_rdy, 0);
        tick();
        chk("t1_done_clr", done, 0); chk("t1_idle", busy, 0);
        chk("t1_cnt", rsp_cnt, 2); chk("t1_sum", rsp_sum, 8'h7F); chk("t1_rd0", rsp_rdata, 8'h41);
        rsp_rd = 1; tick(); rsp_rd = 0;
        chk("t1_rd1", rsp_rdata, 8'h3E); chk("t1_cnt1", rsp_cnt, 1);
        rsp_rd = 1; tick(); rsp_rd = 0;
        chk("t1_cnt0", rsp_cnt, 0);
        rsp_rd = 1; tick(); rsp_rd = 0;
        chk("t1_rd_empty", rsp_cnt, 0);

        // Stalled send: out_rdy high one cycle in three
        wr(8'h50); wr(8'h0D);
        start = 1; tick(); start = 0;
        hs = 0;
        for (int c = 0; c < 30; c++) begin
            out_rdy = (c % 3 == 2);
            if (!out_vld) break;
            if (hs < 2) chk("t2_stable_d", out_d, exp2[hs]);
            if (out_rdy) hs++;
            tick();
        end
        out_rdy = 1;
        chk("t2_hs", hs, 2); chk("t2_vld_off", out_vld, 0); chk("t2_busy", busy, 1);
        rx(8'h3E);
        chk("t2_done", done, 1);
        tick();

        // Command buffer full
        for (int i = 0; i < 33; i++) begin
            if (i == 32) chk("t3_full", cmd_full, 1);
            wr(8'h10 + 8'(i));
        end
        chk("t3_full_hold", cmd_full, 1);
        start = 1; tick(); start = 0;
        n = 0;
        for (int c = 0; c < 60 && out_vld; c++) begin
            chk("t3_byte", out_d, 8'h10 + 8'(n));
            n++;
            tick();
        end
        chk("t3_sent", n, 32); chk("t3_empty", cmd_full, 0);
        rx(8'h3E);
        tick();

        // Reply overflow
        wr(8'h0D);
        start = 1; tick(); start = 0;
        tick();
        for (int i = 0; i < 70; i++) rx(8'h01);
        chk("t4_no_done", done, 0);
        rx(8'h3E);
        chk("t4_done", done, 1); chk("t4_cnt", rsp_cnt, 64);
        chk("t4_ovf", ovf, 1);   chk("t4_sum", rsp_sum, 8'h84);
        tick();
        chk("t4_rd", rsp_rdata, 8'h01);

        // Reset mid-SEND after one of three bytes
        wr(8'hA1); wr(8'hA2); wr(8'hA3);
        start = 1; tick(); start = 0;
        tick();
        chk("t5_second", out_d, 8'hA2);
        rst = 1; tick(); rst = 0;
        chk("t5_vld", out_vld, 0); chk("t5_busy", busy, 0); chk("t5_done", done, 0);
        chk("t5_ovf", ovf, 0);     chk("t5_cnt", rsp_cnt, 0);
        tick();
        chk("t5_no_done", done, 0);
        start = 1; tick(); start = 0;
        chk("t5_empty_done", done, 1); chk("t5_empty_busy", busy, 0); chk("t5_empty_vld", out_vld, 0);
        tick();
        chk("t5_done_pulse", done, 0);

        // Same-cycle write+start; PROMPT echoed during SEND must not end it
        cmd_we = 1; cmd_wd = 8'h77; start = 1; out_rdy = 0;
        tick();
        cmd_we = 0; start = 0;
        chk("t6_vld", out_vld, 1); chk("t6_d", out_d, 8'h77);
        rx(8'h3E);
        chk("t6_busy", busy, 1); chk("t6_vld_hold", out_vld, 1);
        chk("t6_cnt", rsp_cnt, 1); chk("t6_no_done", done, 0);
        out_rdy = 1; tick();
        chk("t6_wait", out_vld, 0); chk("t6_wait_busy", busy, 1);
        rx(8'h3E);
        chk("t6_done", done, 1); chk("t6_cnt2", rsp_cnt, 2); chk("t6_sum", rsp_sum, 8'h7C);
        tick();

`ifdef SDU_HOST_TIMEOUT_EN
        wr(8'h0D);
        start = 1; tick(); start = 0;
        tick();
        n = 0;
        while (!done && n < 300) begin tick(); n++; end
        chk("t7_cycles", n, 100); chk("t7_timeout", timeout, 1);
        tick();
        wr(8'h0D);
        start = 1; tick(); start = 0;
        chk("t7_to_clr", timeout, 0);
        tick();
        n = 0;
        while (!done && n < 400) begin
            in_vld = (n == 50); in_d = 8'h41;
            tick(); n++;
        end
        in_vld = 0;
        chk("t7_restart", n, 151); chk("t7_timeout2", timeout, 1);
        tick();
`else
        chk("t7_timeout_tied", timeout, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sdu_host_agent.md
Name: sdu_host_agent

Overview:
- Host-side counterpart of the debug command processor's byte interfaces: plays the terminal end of the serial debug link.
- Buffers one command line, streams it byte-by-byte into the processor's receive-side byte port, then captures reply bytes from the processor's transmit-side byte port until a prompt byte arrives.
- Used in self-checking benches and on-board loopback tests in place of a PC terminal.
- Reply bytes are read back through a simple read port; a count and a checksum are exported.

Parameters:
CMD_DEPTH, 32, command buffer depth in bytes (power of 2)
RSP_DEPTH, 64, reply buffer depth in bytes (power of 2)
PROMPT, 8'h3E, reply terminator byte ('>')
TIMEOUT_CYC, 1000000, reply inactivity limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_we  in  1  write one byte into the command buffer (honoured only in IDLE)
cmd_wd  in  8  command byte
cmd_full  out  1  command buffer holds CMD_DEPTH bytes
start  in  1  begin a transaction (honoured only in IDLE)
busy  out  1  high in SEND and WAIT_RSP
done  out  1  one-cycle pulse on the transaction's end
out_d  out  8  byte toward the processor's receive side
out_vld  out  1  out_d valid
out_rdy  in  1  processor accepts out_d
in_d  in  8  byte from the processor's transmit side
in_vld  in  1  in_d valid
in_rdy  out  1  agent accepts in_d
rsp_rd  in  1  pop one reply byte (honoured in IDLE/DONE only)
rsp_rdata  out  8  reply byte at the read pointer (combinational from pointer)
rsp_cnt  out  clog2(RSP_DEPTH)+1  reply bytes stored
rsp_sum  out  8  mod-256 sum of all reply bytes received, including PROMPT
ovf  out  1  sticky: reply byte dropped because the buffer was full
timeout  out  1  sticky: transaction ended by inactivity

Behaviour:
- Reset: state IDLE. busy=0, done=0, out_vld=0, out_d=0, in_rdy=0, cmd_full=0, rsp_cnt=0, rsp_sum=0, ovf=0, timeout=0. All pointers are 0. Reset mid-transaction aborts it immediately with no done pulse.
- IDLE:
  - cmd_we with buffer not full appends a byte; cmd_we while full is ignored.
  - start with ≥1 command byte: clear rsp_cnt, rsp_sum, ovf, timeout and the reply pointers; next state SEND.
  - start with an empty buffer: done pulses the next cycle; state stays IDLE.
  - cmd_we and start in the same cycle: the write lands first and is included in the send.
- SEND:
  - out_vld=1, out_d=buffer[rd_ptr]. out_d and out_vld stay stable until out_rdy.
  - On out_vld&&out_rdy, advance rd_ptr.
  - When the last byte is accepted, next cycle out_vld=0, the command buffer is emptied, and the state moves to WAIT_RSP.
  - in_rdy=1 also during SEND, so echo bytes are captured. A PROMPT byte in SEND is stored but does not end the transaction.
- WAIT_RSP: in_rdy=1. Each in_vld&&in_rdy byte is:
  - added to rsp_sum, always;
  - stored and counted in rsp_cnt if rsp_cnt<RSP_DEPTH; otherwise dropped and ovf set.
  - If the byte equals PROMPT, the next state is DONE.
- DONE: lasts one cycle. done=1, in_rdy=0, then back to IDLE.
- Reply readback in IDLE: rsp_rd with rsp_cnt>0 advances the read pointer and decrements rsp_cnt. rsp_rd when empty is ignored.
- Pointers wrap modulo depth. Full/empty are decided by count, not pointer equality.
- Latency: the first out_vld is asserted 1 cycle after start is sampled. done asserts 1 cycle after the PROMPT handshake.

Optional Feature:
- Macro: SDU_HOST_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_RSP and is cleared by every accepted in_d byte.
  - When the count reaches TIMEOUT_CYC, set timeout and go to DONE (done pulses).
  - The counter is cleared in all other states.
- Undefined:
  - No counter is built; timeout is tied to 0.
  - WAIT_RSP waits indefinitely for PROMPT.

Test Plan:
- Write 'P','\r' (0x50,0x0D), start, out_rdy always 1 → out_d sequence 0x50,0x0D on consecutive cycles. Then reply bytes 0x41,0x3E → done 1 cycle after the 0x3E handshake, rsp_cnt=2, rsp_sum=0x7F, readback 0x41,0x3E.
- Same command with out_rdy toggling 1-of-3 cycles → out_d and out_vld stable while stalled, exactly 2 handshakes, no duplicated or lost byte.
- Write 32 bytes, then a 33rd → cmd_full=1, 33rd ignored, exactly 32 bytes sent.
- Reply of 70 bytes 0x01, then 0x3E → rsp_cnt=64, ovf=1, rsp_sum=(70+0x3E) mod 256=0x84.
- Assert rst mid-SEND after 1 of 3 bytes → next cycle out_vld=0, busy=0, no done. A new start with an empty buffer → done pulse only.
- With SDU_HOST_TIMEOUT_EN and TIMEOUT_CYC=100: send 1 byte, no reply → done and timeout=1 exactly 100 cycles after entering WAIT_RSP. A reply byte at cycle 50 restarts the count.
